ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX register. Consumes the `ID_EX_*` bundle. Performs operand forwarding, ALU operation, branch/jump resolution and load-use stall detection. Drives `EX_stall` back to the ID/EX register, a redirect/flush to the front end, and the registered `EX_MEM_*` bundle to the MEM stage.

## Interface
- Parameters:
  - `XLEN`, 32: datapath width.
  - `CNT_W`, 32: width of the performance counters.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ID_EX_branch`, `ID_EX_memread`, `ID_EX_memtoreg`, `ID_EX_memwrite`, `ID_EX_alusrc`, `ID_EX_regwrite`, `ID_EX_unconditional_jmp` in 1 each: control bits from ID/EX.
- `ID_EX_aluop` in 4: ALU op, or branch condition when `ID_EX_branch`=1.
- `ID_EX_imme`, `ID_EX_rs1_data`, `ID_EX_rs2_data`, `ID_EX_pc` in XLEN: operands from ID/EX.
- `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd` in 5: register indices.
- `MEM_WB_rd` in 5, `MEM_WB_regwrite` in 1, `MEM_WB_result` in XLEN: writeback forwarding source.
- `EX_stall` out 1: hold ID/EX and all upstream stages.
- `EX_flush` out 1: squash IF/ID and ID/EX this cycle.
- `EX_target` out XLEN: redirect PC, valid when `EX_flush`=1.
- `EX_MEM_ALU_result`, `EX_MEM_rs2_data` out XLEN; `EX_MEM_rd` out 5; `EX_MEM_memread`, `EX_MEM_memtoreg`, `EX_MEM_memwrite`, `EX_MEM_regwrite` out 1 each: registered EX/MEM bundle.
- `stall_count`, `flush_count` out CNT_W: performance counters.

## Operation
- Forwarding, per source rs1/rs2, evaluated in priority order:
  - Index 0 always uses the `ID_EX_*_data` value.
  - EX/MEM match (`EX_MEM_regwrite`, `EX_MEM_rd`==rs, not `EX_MEM_memread`) selects `EX_MEM_ALU_result`.
  - Otherwise a MEM/WB match (`MEM_WB_regwrite`, `MEM_WB_rd`==rs) selects `MEM_WB_result`.
  - Otherwise the `ID_EX_*_data` value is used.
- Load-use stall:
  - `EX_stall`=1 when `EX_MEM_memread` && `EX_MEM_rd`!=0 && `EX_MEM_rd` equals `ID_EX_rs1` or `ID_EX_rs2`. This is combinational.
  - While stalled, EX/MEM loads a bubble: all control bits 0, data unchanged.
- Operand B is `ID_EX_imme` if `ID_EX_alusrc`, else forwarded rs2.
- ALU ops when `ID_EX_branch`=0, result width XLEN:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI).
  - Codes 11–15 produce 0.
  - Shift amount is B[4:0]. SLT/SLTU produce 0/1.
- Branch conditions when `ID_EX_branch`=1: aluop 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU. Any other code means not taken. Target is pc+imme.
- Jumps when `ID_EX_unconditional_jmp`=1:
  - Result is pc+4.
  - With `ID_EX_alusrc`=0 (JAL) the target is pc+imme.
  - With `ID_EX_alusrc`=1 (JALR) the target is (fwd rs1+imme) with bit0 cleared.
- `EX_flush` = (taken branch or jump) && !`EX_stall`.
- `EX_MEM_regwrite` is forced 0 when `ID_EX_rd`==0.
- `EX_MEM_rs2_data` carries forwarded rs2, used as store data.
- Counters: `stall_count` increments on each `EX_stall` cycle and `flush_count` on each `EX_flush` cycle. Both saturate at all-ones.

## Timing
- All `EX_MEM_*` outputs, counters and the EX stage result are registered; the result appears one clock after ID/EX presents the instruction.
- `EX_stall`, `EX_flush` and `EX_target` are combinational on the current ID/EX and EX/MEM contents. They are valid in the same cycle.
- A load-use stall lasts exactly one cycle:
  - The bubble clears `EX_MEM_memread`.
  - On the next cycle the operand forwards from MEM/WB.
- Stall and taken branch in the same cycle: the stall wins. `EX_flush`=0 and the branch resolves the next cycle using forwarded data.
- Reset, asynchronous: all `EX_MEM_*` outputs and counters become 0, and bubbles are inserted immediately. Asserting reset mid-stall clears the stall state. No instruction is replayed after reset.

## Structure
- Shared package `ex_pkg` holds:
  - the aluop localparams (ADD..PASSB);
  - the branch condition codes (BEQ..BGEU);
  - the bubble constant for the control bits.
- One combinational sub-module, `ex_alu`, with inputs (a, b, aluop) and outputs result plus the compare flags eq, lt and ltu.
- The forwarding muxes, stall/flush logic, EX/MEM register and counters stay in `ex_mem_stage`.

## Test plan
- Back-to-back dependency: ADD x5=3+4 followed by SUB x6=x5−1 → the SUB uses the EX/MEM forward and `EX_MEM_ALU_result`=6. No stall.
- Load-use: LW x7 in EX/MEM followed by ADD using x7 → `EX_stall`=1 for one cycle and the EX/MEM bubble has regwrite=0. The next cycle forwards `MEM_WB_result`=0x1234, `stall_count`=1.
- BLT taken with rs1=−1, rs2=1, pc=0x100, imme=0x20 → `EX_flush`=1, `EX_target`=0x120. BLTU with the same operands → no flush.
- JALR with rs1=0x203, imme=4, pc=0x40 → `EX_target`=0x206 and result 0x44 on the next clock.
- Write to x0 (ADD rd=0) → `EX_MEM_regwrite`=0. A following read of x0 is not forwarded.
- Reset asserted mid-stall → outputs are 0 immediately and the counters are cleared. Releasing reset with no hazard gives `EX_stall`=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU op codes, branch condition
// codes and the EX/MEM control bundle with its bubble value.
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [3:0] BR_BEQ  = 4'd0;
  localparam logic [3:0] BR_BNE  = 4'd1;
  localparam logic [3:0] BR_BLT  = 4'd4;
  localparam logic [3:0] BR_BGE  = 4'd5;
  localparam logic [3:0] BR_BLTU = 4'd6;
  localparam logic [3:0] BR_BGEU = 4'd7;

  typedef struct packed {
    logic memread;
    logic memtoreg;
    logic memwrite;
    logic regwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU with compare flags used for branch resolution.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      aluop,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  logic [4:0] w_shamt;

  assign w_shamt = b[4:0];
  assign eq      = (a == b);
  assign lt      = ($signed(a) < $signed(b));
  assign ltu     = (a < b);

  // Operation select; unused codes yield zero
  always_comb begin
    result = '0;
    case (aluop)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << w_shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> w_shamt;
      ALU_SRA:   result = $signed(a) >>> w_shamt;
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, load-use
// stall detection, EX/MEM pipeline register and saturating perf counters.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_branch,
  input  logic             ID_EX_memread,
  input  logic             ID_EX_memtoreg,
  input  logic             ID_EX_memwrite,
  input  logic             ID_EX_alusrc,
  input  logic             ID_EX_regwrite,
  input  logic             ID_EX_unconditional_jmp,
  input  logic [3:0]       ID_EX_aluop,
  input  logic [XLEN-1:0]  ID_EX_imme,
  input  logic [XLEN-1:0]  ID_EX_rs1_data,
  input  logic [XLEN-1:0]  ID_EX_rs2_data,
  input  logic [XLEN-1:0]  ID_EX_pc,
  input  logic [4:0]       ID_EX_rs1,
  input  logic [4:0]       ID_EX_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic [4:0]       MEM_WB_rd,
  input  logic             MEM_WB_regwrite,
  input  logic [XLEN-1:0]  MEM_WB_result,
  output logic             EX_stall,
  output logic             EX_flush,
  output logic [XLEN-1:0]  EX_target,
  output logic [XLEN-1:0]  EX_MEM_ALU_result,
  output logic [XLEN-1:0]  EX_MEM_rs2_data,
  output logic [4:0]       EX_MEM_rd,
  output logic             EX_MEM_memread,
  output logic             EX_MEM_memtoreg,
  output logic             EX_MEM_memwrite,
  output logic             EX_MEM_regwrite,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_t            r_ctrl;
  logic [XLEN-1:0]  r_alu_result;
  logic [XLEN-1:0]  r_rs2_data;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [XLEN-1:0]  w_fwd_rs1;
  logic [XLEN-1:0]  w_fwd_rs2;
  logic [XLEN-1:0]  w_op_b;
  logic [XLEN-1:0]  w_alu_result;
  logic             w_eq;
  logic             w_lt;
  logic             w_ltu;
  logic             w_br_taken;
  logic [XLEN-1:0]  w_jalr_sum;
  logic [XLEN-1:0]  w_result;
  ctrl_t            w_ctrl_next;

  // Operand forwarding: EX/MEM (non-load) beats MEM/WB; x0 is never forwarded
  always_comb begin
    w_fwd_rs1 = ID_EX_rs1_data;
    if (ID_EX_rs1 != 5'd0) begin
      if (r_ctrl.regwrite && !r_ctrl.memread && (r_rd == ID_EX_rs1))
        w_fwd_rs1 = r_alu_result;
      else if (MEM_WB_regwrite && (MEM_WB_rd == ID_EX_rs1))
        w_fwd_rs1 = MEM_WB_result;
    end
  end

  // Same forwarding priority for rs2
  always_comb begin
    w_fwd_rs2 = ID_EX_rs2_data;
    if (ID_EX_rs2 != 5'd0) begin
      if (r_ctrl.regwrite && !r_ctrl.memread && (r_rd == ID_EX_rs2))
        w_fwd_rs2 = r_alu_result;
      else if (MEM_WB_regwrite && (MEM_WB_rd == ID_EX_rs2))
        w_fwd_rs2 = MEM_WB_result;
    end
  end

  assign w_op_b = ID_EX_alusrc ? ID_EX_imme : w_fwd_rs2;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .a      (w_fwd_rs1),
    .b      (w_op_b),
    .aluop  (ID_EX_aluop),
    .result (w_alu_result),
    .eq     (w_eq),
    .lt     (w_lt),
    .ltu    (w_ltu)
  );

  // Branch condition evaluation from the ALU compare flags
  always_comb begin
    w_br_taken = 1'b0;
    if (ID_EX_branch) begin
      case (ID_EX_aluop)
        BR_BEQ:  w_br_taken = w_eq;
        BR_BNE:  w_br_taken = !w_eq;
        BR_BLT:  w_br_taken = w_lt;
        BR_BGE:  w_br_taken = !w_lt;
        BR_BLTU: w_br_taken = w_ltu;
        BR_BGEU: w_br_taken = !w_ltu;
        default: w_br_taken = 1'b0;
      endcase
    end
  end

  // A load still in EX/MEM cannot feed its consumer until it reaches MEM/WB
  assign EX_stall   = r_ctrl.memread && (r_rd != 5'd0) &&
                      ((r_rd == ID_EX_rs1) || (r_rd == ID_EX_rs2));
  assign EX_flush   = (w_br_taken || ID_EX_unconditional_jmp) && !EX_stall;
  assign w_jalr_sum = w_fwd_rs1 + ID_EX_imme;
  assign EX_target  = (ID_EX_unconditional_jmp && ID_EX_alusrc) ?
                      {w_jalr_sum[XLEN-1:1], 1'b0} : (ID_EX_pc + ID_EX_imme);
  assign w_result   = ID_EX_unconditional_jmp ? (ID_EX_pc + XLEN'(4)) : w_alu_result;

  assign w_ctrl_next = '{memread:  ID_EX_memread,
                         memtoreg: ID_EX_memtoreg,
                         memwrite: ID_EX_memwrite,
                         regwrite: ID_EX_regwrite && (ID_EX_rd != 5'd0)};

  // EX/MEM register: a stall loads a bubble and holds the data fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl       <= CTRL_BUBBLE;
      r_alu_result <= '0;
      r_rs2_data   <= '0;
      r_rd         <= '0;
    end else if (EX_stall) begin
      r_ctrl       <= CTRL_BUBBLE;
    end else begin
      r_ctrl       <= w_ctrl_next;
      r_alu_result <= w_result;
      r_rs2_data   <= w_fwd_rs2;
      r_rd         <= ID_EX_rd;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (EX_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (EX_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign EX_MEM_ALU_result = r_alu_result;
  assign EX_MEM_rs2_data   = r_rs2_data;
  assign EX_MEM_rd         = r_rd;
  assign EX_MEM_memread    = r_ctrl.memread;
  assign EX_MEM_memtoreg   = r_ctrl.memtoreg;
  assign EX_MEM_memwrite   = r_ctrl.memwrite;
  assign EX_MEM_regwrite   = r_ctrl.regwrite;
  assign stall_count       = r_stall_cnt;
  assign flush_count       = r_flush_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with hand-computed expected values.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ID_EX_branch, ID_EX_memread, ID_EX_memtoreg, ID_EX_memwrite;
  logic        ID_EX_alusrc, ID_EX_regwrite, ID_EX_unconditional_jmp;
  logic [3:0]  ID_EX_aluop;
  logic [31:0] ID_EX_imme, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_pc;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite;
  logic [31:0] MEM_WB_result;
  logic        EX_stall, EX_flush;
  logic [31:0] EX_target, EX_MEM_ALU_result, EX_MEM_rs2_data;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_memread, EX_MEM_memtoreg, EX_MEM_memwrite, EX_MEM_regwrite;
  logic [31:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_branch(ID_EX_branch), .ID_EX_memread(ID_EX_memread),
    .ID_EX_memtoreg(ID_EX_memtoreg), .ID_EX_memwrite(ID_EX_memwrite),
    .ID_EX_alusrc(ID_EX_alusrc), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_unconditional_jmp(ID_EX_unconditional_jmp),
    .ID_EX_aluop(ID_EX_aluop), .ID_EX_imme(ID_EX_imme),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
    .ID_EX_rd(ID_EX_rd), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_result(MEM_WB_result),
    .EX_stall(EX_stall), .EX_flush(EX_flush), .EX_target(EX_target),
    .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_rs2_data(EX_MEM_rs2_data),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_memtoreg(EX_MEM_memtoreg), .EX_MEM_memwrite(EX_MEM_memwrite),
    .EX_MEM_regwrite(EX_MEM_regwrite),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    ID_EX_branch = 0; ID_EX_memread = 0; ID_EX_memtoreg = 0; ID_EX_memwrite = 0;
    ID_EX_alusrc = 0; ID_EX_regwrite = 0; ID_EX_unconditional_jmp = 0;
    ID_EX_aluop = 4'd0; ID_EX_imme = 0; ID_EX_rs1_data = 0; ID_EX_rs2_data = 0;
    ID_EX_pc = 0; ID_EX_rs1 = 0; ID_EX_rs2 = 0; ID_EX_rd = 0;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic src, input logic [31:0] imm);
    set_nop();
    ID_EX_aluop = op; ID_EX_rd = rd; ID_EX_regwrite = 1;
    ID_EX_rs1 = rs1; ID_EX_rs1_data = d1;
    ID_EX_rs2 = rs2; ID_EX_rs2_data = d2;
    ID_EX_alusrc = src; ID_EX_imme = imm;
  endtask

  task automatic set_load_x7();
    set_alu(4'd0, 5'd7, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'h40);
    ID_EX_memread = 1; ID_EX_memtoreg = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_nop();
    MEM_WB_rd = 0; MEM_WB_regwrite = 0; MEM_WB_result = 0;
    step();
    check_eq("rst_result", EX_MEM_ALU_result, 32'h0);
    check_eq("rst_regwrite", 32'(EX_MEM_regwrite), 32'h0);
    check_eq("rst_stall", 32'(EX_stall), 32'h0);
    check_eq("rst_stall_cnt", stall_count, 32'h0);
    reset = 0;

    // ADD x5 = 3 + 4, then SUB x6 = x5 - 1 via EX/MEM forward
    set_alu(4'd0, 5'd5, 5'd1, 32'd3, 5'd2, 32'd4, 1'b0, 32'd0);
    step();
    check_eq("add_result", EX_MEM_ALU_result, 32'd7);
    set_alu(4'd1, 5'd6, 5'd5, 32'h99, 5'd0, 32'd0, 1'b1, 32'd1);
    #1 check_eq("sub_no_stall", 32'(EX_stall), 32'h0);
    step();
    check_eq("sub_fwd_result", EX_MEM_ALU_result, 32'd6);
    check_eq("sub_rd", 32'(EX_MEM_rd), 32'd6);
    check_eq("sub_regwrite", 32'(EX_MEM_regwrite), 32'h1);

    // Write to x0 suppressed; read of x0 never forwarded (even from MEM/WB)
    set_alu(4'd0, 5'd0, 5'd1, 32'd10, 5'd2, 32'd20, 1'b0, 32'd0);
    step();
    check_eq("x0_regwrite", 32'(EX_MEM_regwrite), 32'h0);
    check_eq("x0_result", EX_MEM_ALU_result, 32'd30);
    set_alu(4'd0, 5'd8, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'd5);
    MEM_WB_rd = 0; MEM_WB_regwrite = 1; MEM_WB_result = 32'hdead;
    step();
    check_eq("x0_no_fwd", EX_MEM_ALU_result, 32'd5);
    MEM_WB_regwrite = 0;

    // Load-use: LW x7 then ADD using x7
    set_load_x7();
    step();
    check_eq("lw_memread", 32'(EX_MEM_memread), 32'h1);
    set_alu(4'd0, 5'd9, 5'd7, 32'd0, 5'd0, 32'd0, 1'b1, 32'd1);
    #1 check_eq("lu_stall", 32'(EX_stall), 32'h1);
    step();
    check_eq("bubble_regwrite", 32'(EX_MEM_regwrite), 32'h0);
    check_eq("bubble_memread", 32'(EX_MEM_memread), 32'h0);
    check_eq("bubble_data_held", EX_MEM_ALU_result, 32'h40);
    check_eq("stall_cnt_1", stall_count, 32'd1);
    MEM_WB_rd = 5'd7; MEM_WB_regwrite = 1; MEM_WB_result = 32'h1234;
    #1 check_eq("lu_stall_cleared", 32'(EX_stall), 32'h0);
    step();
    check_eq("memwb_fwd_result", EX_MEM_ALU_result, 32'h1235);
    check_eq("memwb_fwd_regwrite", 32'(EX_MEM_regwrite), 32'h1);
    check_eq("stall_cnt_hold", stall_count, 32'd1);
    MEM_WB_rd = 0; MEM_WB_regwrite = 0; MEM_WB_result = 0;

    // BLT taken (-1 < 1), then BLTU not taken with the same operands
    set_nop();
    ID_EX_branch = 1; ID_EX_aluop = 4'd4;
    ID_EX_rs1 = 5'd1; ID_EX_rs1_data = 32'hFFFF_FFFF;
    ID_EX_rs2 = 5'd2; ID_EX_rs2_data = 32'd1;
    ID_EX_pc = 32'h100; ID_EX_imme = 32'h20;
    #1 check_eq("blt_flush", 32'(EX_flush), 32'h1);
    check_eq("blt_target", EX_target, 32'h120);
    step();
    check_eq("flush_cnt_1", flush_count, 32'd1);
    ID_EX_aluop = 4'd6;
    #1 check_eq("bltu_flush", 32'(EX_flush), 32'h0);
    step();
    check_eq("flush_cnt_still_1", flush_count, 32'd1);

    // JALR x1, 4(x3) with x3 = 0x203 at pc 0x40
    set_alu(4'd0, 5'd1, 5'd3, 32'h203, 5'd0, 32'd0, 1'b1, 32'd4);
    ID_EX_unconditional_jmp = 1; ID_EX_pc = 32'h40;
    #1 check_eq("jalr_flush", 32'(EX_flush), 32'h1);
    check_eq("jalr_target", EX_target, 32'h206);
    step();
    check_eq("jalr_link", EX_MEM_ALU_result, 32'h44);
    check_eq("flush_cnt_2", flush_count, 32'd2);

    // Stall wins over a taken branch, then reset lands mid-stall
    set_load_x7();
    step();
    set_nop();
    ID_EX_branch = 1; ID_EX_aluop = 4'd0;
    ID_EX_rs1 = 5'd7; ID_EX_rs2 = 5'd7; ID_EX_pc = 32'h80; ID_EX_imme = 32'h8;
    #1 check_eq("br_stall", 32'(EX_stall), 32'h1);
    check_eq("br_stall_no_flush", 32'(EX_flush), 32'h0);
    #1 reset = 1;
    #1 check_eq("mid_rst_stall", 32'(EX_stall), 32'h0);
    check_eq("mid_rst_memread", 32'(EX_MEM_memread), 32'h0);
    check_eq("mid_rst_result", EX_MEM_ALU_result, 32'h0);
    check_eq("mid_rst_rd", 32'(EX_MEM_rd), 32'h0);
    check_eq("mid_rst_stall_cnt", stall_count, 32'h0);
    check_eq("mid_rst_flush_cnt", flush_count, 32'h0);
    step();
    set_nop();
    reset = 0;
    #1 check_eq("post_rst_stall", 32'(EX_stall), 32'h0);
    step();
    check_eq("post_rst_stall_cnt", stall_count, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
